// File: rtl/regfile_scoreboard.sv
// Parametrised register file with per-register busy scoreboard, registered busy count and debug tap.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module regfile_scoreboard #(
    parameter  int WIDTH     = 32,
    parameter  int DEPTH     = 32,
    parameter  int DEBUG_REG = 1,
    localparam int ADDR_W    = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              ctrl_reset,
    input  logic              ctrl_writeEnable,
    input  logic [ADDR_W-1:0] ctrl_writeReg,
    input  logic [WIDTH-1:0]  data_writeReg,
    input  logic [ADDR_W-1:0] ctrl_readRegA,
    input  logic [ADDR_W-1:0] ctrl_readRegB,
    output logic [WIDTH-1:0]  data_readRegA,
    output logic [WIDTH-1:0]  data_readRegB,
    input  logic              ctrl_markBusy,
    input  logic [ADDR_W-1:0] ctrl_busyReg,
    output logic              busy_readRegA,
    output logic              busy_readRegB,
    output logic [ADDR_W:0]   busy_count,
    output logic [WIDTH-1:0]  debug_reg
);

    // Register 0 has no storage; both arrays start at index 1.
    logic [WIDTH-1:0] regs_q [1:DEPTH-1];
    logic [WIDTH-1:0] regs_d [1:DEPTH-1];
    logic [DEPTH-1:1] busy_q;
    logic [DEPTH-1:1] busy_d;
    logic [ADDR_W:0]  count_q;
    logic [ADDR_W:0]  count_d;

    logic             wr_hit;
    logic             mk_hit;
    logic [DEPTH-1:0] busy_full;
    logic [WIDTH-1:0] stored_a;
    logic [WIDTH-1:0] stored_b;
    logic             stored_busy_a;
    logic             stored_busy_b;

    function automatic logic [ADDR_W:0] popcount(input logic [DEPTH-1:1] v);
        logic [ADDR_W:0] cnt;
        cnt = '0;
        for (int i = 1; i < DEPTH; i++) begin
            cnt = cnt + {{ADDR_W{1'b0}}, v[i]};
        end
        return cnt;
    endfunction

    assign wr_hit = ctrl_writeEnable && (ctrl_writeReg != '0);
    assign mk_hit = ctrl_markBusy && (ctrl_busyReg != '0);

    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (wr_hit) begin
            regs_d[ctrl_writeReg] = data_writeReg;
            busy_d[ctrl_writeReg] = 1'b0;
        end
        // Applied after the write so a re-issuing producer keeps the register busy.
        if (mk_hit) begin
            busy_d[ctrl_busyReg] = 1'b1;
        end
        count_d = popcount(busy_d);
    end

    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            for (int i = 1; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            regs_q  <= regs_d;
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

    assign busy_full     = {busy_q, 1'b0};
    assign stored_a      = (ctrl_readRegA == '0) ? '0 : regs_q[ctrl_readRegA];
    assign stored_b      = (ctrl_readRegB == '0) ? '0 : regs_q[ctrl_readRegB];
    assign stored_busy_a = busy_full[ctrl_readRegA];
    assign stored_busy_b = busy_full[ctrl_readRegB];
    assign busy_count    = count_q;

`ifdef REGFILE_BYPASS_EN
    logic byp_a;
    logic byp_b;
    logic mark_same;

    assign byp_a     = wr_hit && !ctrl_reset && (ctrl_readRegA == ctrl_writeReg);
    assign byp_b     = wr_hit && !ctrl_reset && (ctrl_readRegB == ctrl_writeReg);
    assign mark_same = mk_hit && (ctrl_busyReg == ctrl_writeReg);

    assign data_readRegA = byp_a ? data_writeReg : stored_a;
    assign data_readRegB = byp_b ? data_writeReg : stored_b;
    assign busy_readRegA = byp_a ? mark_same : stored_busy_a;
    assign busy_readRegB = byp_b ? mark_same : stored_busy_b;
`else
    assign data_readRegA = stored_a;
    assign data_readRegB = stored_b;
    assign busy_readRegA = stored_busy_a;
    assign busy_readRegB = stored_busy_b;
`endif

    // Debug tap always shows stored state, never the bypass path.
    generate
        if (DEBUG_REG == 0) begin : g_dbg_zero
            assign debug_reg = '0;
        end else begin : g_dbg_reg
            assign debug_reg = regs_q[DEBUG_REG];
        end
    endgenerate

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench for regfile_scoreboard: stimulus queues expected outputs, a negedge monitor checks them.
module tb_regfile_scoreboard;

    localparam int WIDTH  = 32;
    localparam int DEPTH  = 32;
    localparam int ADDR_W = 5;
    localparam int DBG    = 5;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    localparam int K_RDA = 0, K_RDB = 1, K_BSA = 2, K_BSB = 3, K_CNT = 4, K_DBG = 5;

    logic              clock = 1'b0;
    logic              ctrl_reset;
    logic              ctrl_writeEnable;
    logic [ADDR_W-1:0] ctrl_writeReg;
    logic [WIDTH-1:0]  data_writeReg;
    logic [ADDR_W-1:0] ctrl_readRegA;
    logic [ADDR_W-1:0] ctrl_readRegB;
    logic [WIDTH-1:0]  data_readRegA;
    logic [WIDTH-1:0]  data_readRegB;
    logic              ctrl_markBusy;
    logic [ADDR_W-1:0] ctrl_busyReg;
    logic              busy_readRegA;
    logic              busy_readRegB;
    logic [ADDR_W:0]   busy_count;
    logic [WIDTH-1:0]  debug_reg;

    regfile_scoreboard #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DEBUG_REG(DBG)) dut (
        .clock            (clock),
        .ctrl_reset       (ctrl_reset),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .ctrl_readRegA    (ctrl_readRegA),
        .ctrl_readRegB    (ctrl_readRegB),
        .data_readRegA    (data_readRegA),
        .data_readRegB    (data_readRegB),
        .ctrl_markBusy    (ctrl_markBusy),
        .ctrl_busyReg     (ctrl_busyReg),
        .busy_readRegA    (busy_readRegA),
        .busy_readRegB    (busy_readRegB),
        .busy_count       (busy_count),
        .debug_reg        (debug_reg)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] exp;
        string       name;
    } chk_t;

    chk_t sb[$];
    int   cyc     = 0;
    int   n_vec   = 0;
    int   n_err   = 0;

    always @(posedge clock) cyc = cyc + 1;

    // Monitor: compares every entry tagged for the current cycle, mid-cycle.
    always @(negedge clock) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            chk_t c;
            logic [31:0] act;
            c = sb.pop_front();
            case (c.kind)
                K_RDA:   act = data_readRegA;
                K_RDB:   act = data_readRegB;
                K_BSA:   act = {31'b0, busy_readRegA};
                K_BSB:   act = {31'b0, busy_readRegB};
                K_CNT:   act = {26'b0, busy_count};
                default: act = debug_reg;
            endcase
            n_vec = n_vec + 1;
            if (c.cyc != cyc) begin
                n_err = n_err + 1;
                $display("FAIL %s: stale entry for cycle %0d seen at cycle %0d", c.name, c.cyc, cyc);
            end else if (act !== c.exp) begin
                n_err = n_err + 1;
                $display("FAIL %s: cycle %0d got %h expected %h", c.name, cyc, act, c.exp);
            end
        end
    end

    task automatic expect_out(input int kind, input logic [31:0] exp, input string name);
        chk_t c;
        c.cyc  = cyc;
        c.kind = kind;
        c.exp  = exp;
        c.name = name;
        sb.push_back(c);
    endtask

    // Starts a new cycle and drives all inputs shortly after the rising edge.
    task automatic drive(input logic rst, input logic we, input int wr, input logic [31:0] wd,
                         input int ra, input int rb, input logic mk, input int br);
        @(posedge clock);
        #1;
        ctrl_reset       = rst;
        ctrl_writeEnable = we;
        ctrl_writeReg    = ADDR_W'(wr);
        data_writeReg    = wd;
        ctrl_readRegA    = ADDR_W'(ra);
        ctrl_readRegB    = ADDR_W'(rb);
        ctrl_markBusy    = mk;
        ctrl_busyReg     = ADDR_W'(br);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: timeout at cycle %0d, %0d checks pending", cyc, sb.size());
        $fatal(1, "timeout");
    end

    initial begin
        ctrl_reset = 1'b1; ctrl_writeEnable = 1'b0; ctrl_writeReg = '0; data_writeReg = '0;
        ctrl_readRegA = '0; ctrl_readRegB = '0; ctrl_markBusy = 1'b0; ctrl_busyReg = '0;

        drive(1, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0);

        // Post-reset sweep over every address on both ports.
        for (int a = 0; a < DEPTH; a++) begin
            drive(0, 0, 0, 0, a, DEPTH - 1 - a, 0, 0);
            expect_out(K_RDA, 0, "reset_rdA");
            expect_out(K_RDB, 0, "reset_rdB");
            expect_out(K_BSA, 0, "reset_busyA");
            expect_out(K_BSB, 0, "reset_busyB");
            expect_out(K_CNT, 0, "reset_count");
            expect_out(K_DBG, 0, "reset_debug");
        end

        drive(0, 1, 5, 32'hDEADBEEF, 5, 0, 0, 0);
        expect_out(K_RDA, BYP ? 32'hDEADBEEF : 32'h0, "wr5_same_cycle");
        expect_out(K_DBG, 0, "dbg_not_bypassed");
        drive(0, 0, 0, 0, 5, 0, 0, 0);
        expect_out(K_RDA, 32'hDEADBEEF, "rd5_A");
        expect_out(K_RDB, 0, "rd0_B");
        expect_out(K_DBG, 32'hDEADBEEF, "dbg_r5");

        drive(0, 1, 0, 32'h1, 0, 0, 0, 0);
        expect_out(K_RDA, 0, "wr0_same_cycle");
        drive(0, 0, 0, 0, 0, 5, 0, 0);
        expect_out(K_RDA, 0, "r0_stays_zero");
        expect_out(K_RDB, 32'hDEADBEEF, "r5_kept");

        drive(0, 0, 0, 0, 3, 0, 1, 3);
        expect_out(K_CNT, 0, "count_before_mark");
        drive(0, 0, 0, 0, 7, 3, 1, 7);
        expect_out(K_CNT, 1, "count_after_r3");
        expect_out(K_BSA, 0, "r7_not_yet_busy");
        expect_out(K_BSB, 1, "r3_busy");
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        expect_out(K_CNT, 2, "count_after_r7");
        expect_out(K_BSA, 0, "r0_busy_zero");
        drive(0, 0, 0, 0, 3, 7, 0, 0);
        expect_out(K_CNT, 2, "count_mark_r0_ignored");
        expect_out(K_BSA, 1, "r3_busy_held");
        expect_out(K_BSB, 1, "r7_busy_held");

        drive(0, 1, 3, 32'h33, 3, 7, 0, 0);
        expect_out(K_BSA, BYP ? 0 : 1, "wr3_busy_same_cycle");
        expect_out(K_RDA, BYP ? 32'h33 : 32'h0, "wr3_data_same_cycle");
        drive(0, 0, 0, 0, 3, 7, 0, 0);
        expect_out(K_CNT, 1, "count_after_clear_r3");
        expect_out(K_BSA, 0, "r3_cleared");
        expect_out(K_RDA, 32'h33, "r3_data");
        expect_out(K_BSB, 1, "r7_still_busy");

        drive(0, 1, 7, 32'h55, 7, 0, 1, 7);
        expect_out(K_RDA, BYP ? 32'h55 : 32'h0, "wr_mark_r7_data_same");
        expect_out(K_BSA, 1, "wr_mark_r7_busy_same");
        drive(0, 0, 0, 0, 7, 0, 0, 0);
        expect_out(K_RDA, 32'h55, "wr_mark_r7_data");
        expect_out(K_BSA, 1, "mark_wins_busy");
        expect_out(K_CNT, 1, "count_unchanged_r7");

        drive(0, 1, 9, 32'hA5A5, 9, 9, 0, 0);
        expect_out(K_RDA, BYP ? 32'hA5A5 : 32'h0, "wr9_rdA_same");
        expect_out(K_RDB, BYP ? 32'hA5A5 : 32'h0, "wr9_rdB_same");
        drive(0, 0, 0, 0, 9, 5, 0, 0);
        expect_out(K_RDA, 32'hA5A5, "wr9_next");
        expect_out(K_RDB, 32'hDEADBEEF, "r5_after_r9");

        drive(0, 1, 7, 32'h77, 7, 10, 1, 10);
        expect_out(K_BSA, BYP ? 0 : 1, "wr7_mark10_busyA_same");
        expect_out(K_BSB, 0, "r10_not_yet_busy");
        drive(0, 0, 0, 0, 7, 10, 0, 0);
        expect_out(K_RDA, 32'h77, "r7_rewritten");
        expect_out(K_BSA, 0, "r7_cleared");
        expect_out(K_BSB, 1, "r10_busy");
        expect_out(K_CNT, 1, "count_wr_mark_split");

        // Reset with a write and a mark pending: both must be lost, bypass suppressed.
        drive(1, 1, 12, 32'h1234, 12, 12, 1, 13);
        expect_out(K_RDA, 0, "reset_cycle_no_bypass");
        expect_out(K_CNT, 1, "count_pre_reset_edge");
        drive(0, 0, 0, 0, 5, 12, 0, 0);
        expect_out(K_RDA, 0, "post_reset_r5");
        expect_out(K_RDB, 0, "post_reset_r12");
        expect_out(K_CNT, 0, "post_reset_count");
        expect_out(K_DBG, 0, "post_reset_debug");
        drive(0, 0, 0, 0, 10, 13, 0, 0);
        expect_out(K_BSA, 0, "post_reset_busy10");
        expect_out(K_BSB, 0, "post_reset_busy13");

        drive(0, 1, 5, 32'hCAFE, 0, 0, 1, 4);
        drive(1, 1, 6, 32'hBEEF, 0, 0, 1, 6);
        expect_out(K_DBG, 32'hCAFE, "dbg_before_hold_reset");
        expect_out(K_CNT, 1, "count_before_hold_reset");
        drive(1, 1, 6, 32'hBEEF, 6, 5, 1, 6);
        expect_out(K_CNT, 0, "hold_reset_count");
        expect_out(K_RDB, 0, "hold_reset_r5");
        drive(0, 0, 0, 0, 6, 4, 0, 0);
        expect_out(K_RDA, 0, "hold_reset_r6");
        expect_out(K_BSA, 0, "hold_reset_busy6");
        expect_out(K_BSB, 0, "hold_reset_busy4");
        expect_out(K_DBG, 0, "hold_reset_debug");
        expect_out(K_CNT, 0, "hold_reset_count_after");

        drive(0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        #1;
        if (sb.size() != 0) begin
            n_err = n_err + 1;
            $display("FAIL drain: %0d checks left unserviced, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
